// File: rtl/telemetry_rx.sv
// telemetry_rx: 8N1 serial receiver and packet parser for the e-bike telemetry link (AA 55 + 6 payload bytes).
// Optional macro TELEM_RX_NIBBLE_CHK_EN rejects packets whose hi bytes carry a nonzero upper nibble.
`timescale 1ns/1ps
module telemetry_rx #(
    parameter int BAUD_DIV = 2604,
    parameter int GAP_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic [11:0] batt_v,
    output logic [11:0] curr,
    output logic [11:0] torque,
    output logic        vld,
    output logic        err
);
    localparam int CNT_W     = $clog2(BAUD_DIV + 1);
    localparam int GAP_LIMIT = GAP_BITS * BAUD_DIV;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
    localparam logic [CNT_W-1:0] BAUD_FULL = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_LIMIT - 1);
    localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {HUNT_AA, HUNT_55, PAYLOAD} parse_state_t;

    rx_state_t          rx_state, rx_next;
    parse_state_t       p_state, p_next;
    logic               rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0]   baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         rx_byte;
    logic               byte_rdy, frame_err;
    logic               tick, ld_half, ld_full, shift_en, fire_rdy, fire_ferr;
    logic [2:0]         idx;
    logic [39:0]        shadow;
    logic [GAP_W-1:0]   gap_cnt;
    logic               gap_run, gap_clr, store, update, enter_payload, shadow_clr;
    logic               vld_next, err_next, pkt_bad;
    logic               unused_nibbles;

    // rx_prev gives the falling-edge detector one more registered copy of the synchronized line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign tick = (baud_cnt == CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next   = rx_state;
        ld_half   = 1'b0;
        ld_full   = 1'b0;
        shift_en  = 1'b0;
        fire_rdy  = 1'b0;
        fire_ferr = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_next = RX_START;
                    ld_half = 1'b1;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (!rx_sync) begin
                        rx_next = RX_DATA;
                        ld_full = 1'b1;
                    end else begin
                        rx_next = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    ld_full  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                // Returning to IDLE at mid-stop lets a back-to-back start bit be caught
                if (tick) begin
                    if (rx_sync) begin
                        fire_rdy = 1'b1;
                        rx_next  = RX_IDLE;
                    end else begin
                        fire_ferr = 1'b1;
                        rx_next   = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                if (rx_sync) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            rx_byte   <= '0;
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_rdy  <= fire_rdy;
            frame_err <= fire_ferr;
            if (ld_half)              baud_cnt <= BAUD_HALF;
            else if (ld_full)         baud_cnt <= BAUD_FULL;
            else if (baud_cnt != '0)  baud_cnt <= baud_cnt - CNT_ONE;
            if (ld_half) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                rx_byte <= {rx_sync, rx_byte[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    assign gap_run = (p_state != HUNT_AA) && (rx_state == RX_IDLE);

    // Priority frame error > byte > gap timeout keeps vld and err mutually exclusive
    always_comb begin
        p_next        = p_state;
        store         = 1'b0;
        update        = 1'b0;
        enter_payload = 1'b0;
        shadow_clr    = 1'b0;
        gap_clr       = 1'b0;
        vld_next      = 1'b0;
        err_next      = 1'b0;
        if (frame_err) begin
            p_next   = HUNT_AA;
            err_next = 1'b1;
            gap_clr  = 1'b1;
        end else if (byte_rdy) begin
            gap_clr = 1'b1;
            case (p_state)
                HUNT_AA: begin
                    if (rx_byte == 8'hAA) p_next = HUNT_55;
                end
                HUNT_55: begin
                    if (rx_byte == 8'h55) begin
                        p_next        = PAYLOAD;
                        enter_payload = 1'b1;
                    end else if (rx_byte != 8'hAA) begin
                        p_next   = HUNT_AA;
                        err_next = 1'b1;
                    end
                end
                PAYLOAD: begin
                    store = 1'b1;
                    if (idx == 3'd5) begin
                        p_next = HUNT_AA;
                        if (pkt_bad) begin
                            err_next = 1'b1;
                        end else begin
                            update   = 1'b1;
                            vld_next = 1'b1;
                        end
                    end
                end
                default: p_next = HUNT_AA;
            endcase
        end else if (gap_run && (gap_cnt == GAP_LAST)) begin
            p_next     = HUNT_AA;
            err_next   = 1'b1;
            gap_clr    = 1'b1;
            shadow_clr = 1'b1;
        end
    end

`ifdef TELEM_RX_NIBBLE_CHK_EN
    logic nib_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nib_bad <= 1'b0;
        else if (enter_payload)
            nib_bad <= 1'b0;
        else if (store && !idx[0] && (rx_byte[7:4] != 4'h0))
            nib_bad <= 1'b1;
    end

    assign pkt_bad = nib_bad;
`else
    assign pkt_bad = 1'b0;
`endif

    // The last payload byte is used straight from rx_byte, so the shadow holds only bytes 0-4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state <= HUNT_AA;
            idx     <= '0;
            shadow  <= '0;
            gap_cnt <= '0;
            batt_v  <= '0;
            curr    <= '0;
            torque  <= '0;
            vld     <= 1'b0;
            err     <= 1'b0;
        end else begin
            p_state <= p_next;
            vld     <= vld_next;
            err     <= err_next;
            if (gap_clr || (p_state == HUNT_AA)) gap_cnt <= '0;
            else if (gap_run)                    gap_cnt <= gap_cnt + GAP_ONE;
            if (enter_payload)  idx <= '0;
            else if (store)     idx <= idx + 3'd1;
            if (shadow_clr) begin
                shadow <= '0;
            end else if (store) begin
                case (idx)
                    3'd0:    shadow[7:0]   <= rx_byte;
                    3'd1:    shadow[15:8]  <= rx_byte;
                    3'd2:    shadow[23:16] <= rx_byte;
                    3'd3:    shadow[31:24] <= rx_byte;
                    3'd4:    shadow[39:32] <= rx_byte;
                    default: ;
                endcase
            end
            if (update) begin
                batt_v <= {shadow[3:0], shadow[15:8]};
                curr   <= {shadow[19:16], shadow[31:24]};
                torque <= {shadow[35:32], rx_byte};
            end
        end
    end

    assign unused_nibbles = ^{shadow[7:4], shadow[23:20], shadow[39:36]};

endmodule
